// File: rtl/nios_system_switch_poller_pkg.sv
`default_nettype none
// ============================================================================
// nios_system_switch_poller_pkg - FSM encoding and shared constants for the
// Avalon-MM switch poller.                                     Revision: 1.0
// ============================================================================
package nios_system_switch_poller_pkg;

  localparam int         DEFAULT_DATA_WIDTH = 8;
  localparam logic [1:0] SWITCH_ADDR        = 2'd0;

  typedef logic [1:0] poll_state_t;

  localparam poll_state_t ST_IDLE    = 2'd0;
  localparam poll_state_t ST_READ    = 2'd1;
  localparam poll_state_t ST_CAPTURE = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int count_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_switch_poller_if.sv
`default_nettype none
// ============================================================================
// nios_system_switch_poller_if - Avalon-MM read channel between the poller
// (master) and the switch PIO (slave).                         Revision: 1.0
// ============================================================================
interface nios_system_switch_poller_if;

  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata
  );

endinterface
`default_nettype wire

// File: rtl/nios_system_switch_poller_debouncer.sv
`default_nettype none
// ============================================================================
// nios_system_debouncer - accepts a sample once it has repeated DEBOUNCE_COUNT
// consecutive polls; only exists when SWITCH_POLLER_DEBOUNCE_EN is defined.
// Revision: 1.0
// ============================================================================
`ifdef SWITCH_POLLER_DEBOUNCE_EN
module nios_system_debouncer
  import nios_system_switch_poller_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] stable_value,
  output logic                  accept
);

  localparam int                 MATCH_W   = count_width(DEBOUNCE_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  logic [DATA_WIDTH-1:0] candidate_q, candidate_d;
  logic [MATCH_W-1:0]    match_q, match_d;

  always_comb begin
    candidate_d = candidate_q;
    match_d     = match_q;
    accept      = 1'b0;
    if (sample_valid) begin
      if (sample != candidate_q) begin
        candidate_d = sample;
        match_d     = MATCH_ONE;
      end else if (match_q < MATCH_MAX) begin
        match_d = match_q + MATCH_ONE;
      end
      // Uses the updated count so DEBOUNCE_COUNT=1 accepts on first sight.
      accept = (match_d >= MATCH_MAX) && (sample != stable_value);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate_q <= '0;
      match_q     <= '0;
    end else begin
      candidate_q <= candidate_d;
      match_q     <= match_d;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/nios_system_switch_poller.sv
`default_nettype none
// ============================================================================
// nios_system_switch_poller - periodic Avalon-MM poll of the switch PIO with
// change strobe and level irq; SWITCH_POLLER_DEBOUNCE_EN adds debouncing.
// Revision: 1.0
// ============================================================================
module nios_system_switch_poller
  import nios_system_switch_poller_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int POLL_DIV       = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  nios_system_switch_poller_if.master        avm,
  output logic [DATA_WIDTH-1:0]              switch_state,
  output logic                               changed,
  output logic                               irq,
  input  logic                               irq_ack
);

  localparam int               CNT_W      = count_width(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_DIV - 1);
  // An out-of-range configuration simply never polls.
  localparam bit               CFG_OK     = (POLL_DIV >= 1) && (DEBOUNCE_COUNT >= 1);

  poll_state_t           state_q, state_d;
  logic [CNT_W-1:0]      poll_cnt_q, poll_cnt_d;
  logic                  avm_read_q, avm_read_d;
  logic [DATA_WIDTH-1:0] switch_state_q, switch_state_d;
  logic                  changed_q, changed_d;
  logic                  irq_q, irq_d;

  logic                  poll_en;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample;
  logic                  accept;

  assign poll_en      = enable && CFG_OK;
  assign sample_valid = (state_q == ST_CAPTURE);
  assign sample       = avm.avm_readdata[DATA_WIDTH-1:0];

`ifdef SWITCH_POLLER_DEBOUNCE_EN
  nios_system_debouncer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debouncer (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .stable_value (switch_state_q),
    .accept       (accept)
  );
`else
  assign accept = sample_valid && (sample != switch_state_q);
`endif

  generate
    if (DATA_WIDTH < 32) begin : g_unused_readdata
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm.avm_readdata[31:DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    poll_cnt_d     = poll_cnt_q;
    avm_read_d     = 1'b0;
    switch_state_d = switch_state_q;
    changed_d      = 1'b0;
    // Acknowledge clears, but a same-cycle accept below wins.
    irq_d          = irq_q & ~irq_ack;

    case (state_q)
      ST_IDLE: begin
        if (!poll_en) begin
          poll_cnt_d = CNT_RELOAD;
        end else if (poll_cnt_q == '0) begin
          state_d    = ST_READ;
          avm_read_d = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q - CNT_W'(1);
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d    = ST_IDLE;
        poll_cnt_d = CNT_RELOAD;
        if (accept) begin
          switch_state_d = sample;
          changed_d      = 1'b1;
          irq_d          = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        poll_cnt_d = CNT_RELOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      poll_cnt_q     <= CNT_RELOAD;
      avm_read_q     <= 1'b0;
      switch_state_q <= '0;
      changed_q      <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      avm_read_q     <= avm_read_d;
      switch_state_q <= switch_state_d;
      changed_q      <= changed_d;
      irq_q          <= irq_d;
    end
  end

  assign avm.avm_address = SWITCH_ADDR;
  assign avm.avm_read    = avm_read_q;
  assign switch_state    = switch_state_q;
  assign changed         = changed_q;
  assign irq             = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_switch_poller.sv
`default_nettype none
// ============================================================================
// tb_nios_system_switch_poller - scoreboard bench for the switch poller with
// POLL_DIV=4, DEBOUNCE_COUNT=3.                                Revision: 1.0
// ============================================================================
module tb_nios_system_switch_poller;

  localparam int DW = 8;
  localparam int PD = 4;
  localparam int DC = 3;
`ifdef SWITCH_POLLER_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int PRE_POLLS = DEB ? DC - 1 : 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          irq_ack;
  logic [DW-1:0] switch_state;
  logic          changed;
  logic          irq;

  nios_system_switch_poller_if avm_if ();

  nios_system_switch_poller #(
    .DATA_WIDTH     (DW),
    .POLL_DIV       (PD),
    .DEBOUNCE_COUNT (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .avm          (avm_if),
    .switch_state (switch_state),
    .changed      (changed),
    .irq          (irq),
    .irq_ack      (irq_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and reference model
  typedef struct packed {
    logic [DW-1:0] sw;
    logic          chg;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e_push, e_pop;
  logic [DW-1:0] poll_data = '0;
  logic [31:0]   hi_bits;
  logic [DW-1:0] m_sw, m_cand;
  int            m_match;
  logic          m_irq;
  logic          m_acc;
  logic          m_acc_pending;
  int            phase = 0;
  int            chg_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_sw = '0; m_cand = '0; m_match = 0; m_irq = 1'b0;
      m_acc_pending = 1'b0; phase = 0;
      sbq.delete();
      avm_if.avm_readdata = '0;
      check_eq("rst_irq", irq, 0);
      check_eq("rst_read", avm_if.avm_read, 0);
    end else begin
      check_eq("addr", avm_if.avm_address, 0);
      if (changed) chg_cnt++;
      if (phase == 2) begin
        if (sbq.size() == 0) begin
          check_eq("sb_underflow", sbq.size(), 1);
        end else begin
          e_pop = sbq.pop_front();
          check_eq("sb_switch_state", switch_state, e_pop.sw);
          check_eq("sb_changed", changed, e_pop.chg);
        end
        m_irq = m_acc_pending ? 1'b1 : (m_irq & ~irq_ack);
        m_acc_pending = 1'b0;
        phase = 3;
      end else begin
        if (phase == 3) check_eq("changed_width", changed, 0);
        if (phase == 1) check_eq("read_width", avm_if.avm_read, 0);
        m_irq = m_irq & ~irq_ack;
        if (phase == 1) begin
          phase = 2;
        end else if (avm_if.avm_read) begin
          // Slave returns data the cycle after the read; upper bits are noise.
          hi_bits = $urandom();
          avm_if.avm_readdata = {hi_bits[31:DW], poll_data};
          if (DEB) begin
            if (poll_data != m_cand) begin
              m_cand = poll_data;
              m_match = 1;
            end else if (m_match < DC) begin
              m_match++;
            end
            m_acc = (m_match >= DC) && (poll_data != m_sw);
          end else begin
            m_acc = (poll_data != m_sw);
          end
          if (m_acc) m_sw = poll_data;
          e_push.sw  = m_sw;
          e_push.chg = m_acc;
          sbq.push_back(e_push);
          m_acc_pending = m_acc;
          phase = 1;
        end else begin
          phase = 0;
        end
      end
      check_eq("irq", irq, m_irq);
    end
  end

  task automatic wait_read();
    for (int i = 0; i < 4 * PD + 8; i++) begin
      @(posedge clk); #1;
      if (avm_if.avm_read) return;
    end
    check_eq("read_timeout", avm_if.avm_read, 1);
  endtask

  task automatic do_poll(input logic [DW-1:0] d);
    poll_data = d;
    wait_read();
    repeat (2) @(posedge clk);
    #2;
  endtask

  int c0;

  initial begin
    reset = 1'b1; enable = 1'b0; irq_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("rst_switch_state", switch_state, 0);
    check_eq("rst_changed", changed, 0);
    check_eq("rst_irq_out", irq, 0);
    check_eq("rst_avm_read", avm_if.avm_read, 0);
    check_eq("rst_avm_address", avm_if.avm_address, 0);

    // Read cadence: first read POLL_DIV cycles after release, then every POLL_DIV+2
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("read_cycle%0d", n), avm_if.avm_read,
               (n >= PD) && ((n - PD) % (PD + 2) == 0));
    end

    // Alternating samples
    for (int k = 0; k < 6; k++) do_poll((k % 2 == 0) ? 8'h01 : 8'h02);
    check_eq("alt_switch_state", switch_state, m_sw);

    // Held value is accepted with a single changed pulse
    c0 = chg_cnt;
    repeat (DC) do_poll(8'h5A);
    check_eq("hold_switch_state", switch_state, 8'h5A);
    check_eq("hold_changed_pulses", chg_cnt - c0, 1);
    check_eq("hold_irq", irq, 1);

    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check_eq("ack_clears_irq", irq, 0);

    // Acknowledge coinciding with a new accept leaves irq set
    repeat (PRE_POLLS) do_poll(8'h0F);
    check_eq("pre_accept_irq", irq, 0);
    poll_data = 8'h0F;
    wait_read();
    @(negedge clk);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check_eq("ack_accept_switch_state", switch_state, 8'h0F);
    check_eq("ack_accept_irq", irq, 1);
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    check_eq("late_ack_irq", irq, 0);

    // Enable dropped during READ: capture completes, then polling stops
    poll_data = 8'h0F;
    wait_read();
    @(negedge clk); enable = 1'b0;
    repeat (2) @(posedge clk); #2;
    check_eq("drop_capture_done", sbq.size(), 0);
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      check_eq("disabled_no_read", avm_if.avm_read, 0);
    end
    @(negedge clk); enable = 1'b1;
    for (int n = 1; n <= PD; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("reenable_read%0d", n), avm_if.avm_read, n == PD);
    end

    // Reset in the middle of IDLE clears everything at once
    repeat (DC) do_poll(8'hC3);
    check_eq("pre_reset_switch_state", switch_state, 8'hC3);
    check_eq("pre_reset_irq", irq, 1);
    @(negedge clk); reset = 1'b1;
    #1;
    check_eq("midreset_switch_state", switch_state, 0);
    check_eq("midreset_changed", changed, 0);
    check_eq("midreset_irq", irq, 0);
    check_eq("midreset_avm_read", avm_if.avm_read, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= PD; n++) begin
      @(posedge clk); #1;
      check_eq($sformatf("post_reset_read%0d", n), avm_if.avm_read, n == PD);
    end
    check_eq("post_reset_switch_state", switch_state, 0);
    repeat (4) @(posedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
